// File: rtl/dcache_nway_wb_if.sv
`default_nettype none
// ============================================================================
// dcache_nway_wb_if : CPU load/store port and block memory port of the cache
// Revision: 1.0
// ============================================================================
interface dcache_nway_wb_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512
);
    logic                   req_i;
    logic                   we_i;
    logic [1:0]             store_type_i;
    logic [ADDR_WIDTH-1:0]  addr_i;
    logic [63:0]            write_data_i;
    logic [63:0]            read_data_o;
    logic                   stall_o;
    logic                   store_ma_o;
    logic                   mem_req_o;
    logic                   mem_we_o;
    logic [ADDR_WIDTH-1:0]  mem_addr_o;
    logic [BLOCK_WIDTH-1:0] mem_wdata_o;
    logic [BLOCK_WIDTH-1:0] mem_rdata_i;
    logic                   mem_ready_i;

    modport slave (
        input  req_i, we_i, store_type_i, addr_i, write_data_i, mem_rdata_i, mem_ready_i,
        output read_data_o, stall_o, store_ma_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_i, we_i, store_type_i, addr_i, write_data_i, mem_rdata_i, mem_ready_i,
        input  read_data_o, stall_o, store_ma_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/dcache_nway_wb.sv
`default_nettype none
// ============================================================================
// dcache_nway_wb : N-way set-associative write-back data cache, tree-PLRU
// Revision: 1.0
// ============================================================================
module dcache_nway_wb #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512,
    parameter int N_WAYS      = 4,
    parameter int SET_COUNT   = 4
) (
    input  logic            clk_i,
    input  logic            arst_i,
    dcache_nway_wb_if.slave bus
);
    localparam int OFF_BITS  = $clog2(BLOCK_WIDTH / 8);
    localparam int IDX_BITS  = $clog2(SET_COUNT);
    localparam int TAG_BITS  = ADDR_WIDTH - OFF_BITS - IDX_BITS;
    localparam int WAY_BITS  = $clog2(N_WAYS);
    localparam int PLRU_BITS = N_WAYS - 1;
    localparam int DW_BYTES  = DATA_WIDTH / 8;
    localparam logic [OFF_BITS-1:0] DW_MASK = ~OFF_BITS'(DW_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WB     = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    logic [BLOCK_WIDTH-1:0] data_q  [SET_COUNT][N_WAYS];
    logic [TAG_BITS-1:0]    tag_q   [SET_COUNT][N_WAYS];
    logic [N_WAYS-1:0]      valid_q [SET_COUNT];
    logic [N_WAYS-1:0]      dirty_q [SET_COUNT];
    logic [PLRU_BITS-1:0]   plru_q  [SET_COUNT];

    state_t                 state_q;
    state_t                 state_d;
    logic                   mem_req_q;
    logic                   mem_we_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic [WAY_BITS-1:0]    victim_q;

    logic [IDX_BITS-1:0]    idx;
    logic [TAG_BITS-1:0]    req_tag;
    logic [OFF_BITS-1:0]    byte_off;
    logic [OFF_BITS+2:0]    dw_base;
    logic                   hit;
    logic [WAY_BITS-1:0]    hit_way;
    logic [BLOCK_WIDTH-1:0] hit_block;
    logic [BLOCK_WIDTH-1:0] merged;
    logic [7:0]             size_mask;
    logic [7:0]             lane_mask;
    logic [DATA_WIDTH-1:0]  lane_data;
    logic                   mis_align;
    logic                   store_ma;
    logic                   lookup_hit;
    logic                   store_hit;
    logic                   refill_done;
    logic                   stall;
    logic [WAY_BITS-1:0]    plru_victim;
    logic [PLRU_BITS-1:0]   plru_upd;
    logic [ADDR_WIDTH-1:0]  wb_addr;
    logic [ADDR_WIDTH-1:0]  fill_addr;

    assign idx       = bus.addr_i[OFF_BITS +: IDX_BITS];
    assign req_tag   = bus.addr_i[ADDR_WIDTH-1 -: TAG_BITS];
    assign byte_off  = bus.addr_i[OFF_BITS-1:0];
    assign dw_base   = {byte_off & DW_MASK, 3'b000};
    assign wb_addr   = {tag_q[idx][plru_victim], idx, {OFF_BITS{1'b0}}};
    assign fill_addr = {req_tag, idx, {OFF_BITS{1'b0}}};

    // Descending scan so the lowest matching way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    assign hit_block = data_q[idx][hit_way];

    always_comb begin
        case (bus.store_type_i)
            2'b00:   begin size_mask = 8'h01; mis_align = 1'b0;                 end
            2'b01:   begin size_mask = 8'h03; mis_align = bus.addr_i[0];        end
            2'b10:   begin size_mask = 8'h0F; mis_align = |bus.addr_i[1:0];     end
            default: begin size_mask = 8'hFF; mis_align = |bus.addr_i[2:0];     end
        endcase
        lane_mask = size_mask << bus.addr_i[2:0];
        lane_data = bus.write_data_i << {bus.addr_i[2:0], 3'b000};
    end

    always_comb begin
        merged = hit_block;
        for (int b = 0; b < DW_BYTES; b++) begin
            if (lane_mask[b]) begin
                merged[int'(dw_base) + 8 * b +: 8] = lane_data[8 * b +: 8];
            end
        end
    end

    assign store_ma    = bus.req_i & bus.we_i & mis_align;
    assign lookup_hit  = (state_q == S_IDLE) & bus.req_i & ~store_ma & hit;
    assign store_hit   = lookup_hit & bus.we_i;
    assign refill_done = (state_q == S_REFILL) & bus.mem_ready_i;

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
    always_comb begin
        int vnode;
        vnode       = 0;
        plru_victim = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
            plru_victim = (plru_victim << 1) | WAY_BITS'(plru_q[idx][vnode]);
            vnode       = 2 * vnode + 1 + int'(plru_q[idx][vnode]);
        end
    end

    always_comb begin
        int unode;
        unode    = 0;
        plru_upd = plru_q[idx];
        for (int l = 0; l < WAY_BITS; l++) begin
            plru_upd[unode] = ~hit_way[WAY_BITS-1-l];
            unode           = 2 * unode + 1 + int'(hit_way[WAY_BITS-1-l]);
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_i && !store_ma && !hit) begin
                    stall   = 1'b1;
                    state_d = (valid_q[idx][plru_victim] && dirty_q[idx][plru_victim])
                              ? S_WB : S_REFILL;
                end
            end
            S_WB: begin
                stall = 1'b1;
                if (bus.mem_ready_i) state_d = S_REFILL;
            end
            S_REFILL: begin
                stall = 1'b1;
                if (bus.mem_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            victim_q   <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= (state_d != S_IDLE);
            mem_we_q  <= (state_d == S_WB);
            if (state_q == S_IDLE && state_d != S_IDLE) victim_q <= plru_victim;
            if (state_d == S_WB && state_q != S_WB) begin
                mem_addr_q <= wb_addr;
            end else if (state_d == S_REFILL && state_q != S_REFILL) begin
                mem_addr_q <= fill_addr;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int s = 0; s < SET_COUNT; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (lookup_hit) begin
                plru_q[idx] <= plru_upd;
                if (bus.we_i) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (refill_done) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
        end
    end

    // Line storage carries no reset; valid bits gate every use of it.
    always_ff @(posedge clk_i) begin
        if (store_hit) data_q[idx][hit_way] <= merged;
        if (refill_done) begin
            data_q[idx][victim_q] <= bus.mem_rdata_i;
            tag_q[idx][victim_q]  <= req_tag;
        end
    end

    assign bus.read_data_o = hit_block[dw_base +: DATA_WIDTH];
    assign bus.stall_o     = stall;
    assign bus.store_ma_o  = store_ma;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = data_q[idx][victim_q];

endmodule
`default_nettype wire

// File: tb/tb_dcache_nway_wb.sv
`default_nettype none
// ============================================================================
// tb_dcache_nway_wb : directed bench for the 4-way, 4-set write-back cache
// Revision: 1.0
// ============================================================================
module tb_dcache_nway_wb;
    localparam int AW = 64;
    localparam int BW = 512;

    logic clk_i  = 1'b0;
    logic arst_i = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [BW-1:0] line0;

    dcache_nway_wb_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) bus ();

    dcache_nway_wb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(64), .BLOCK_WIDTH(BW), .N_WAYS(4), .SET_COUNT(4)
    ) dut (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Memory returns doubleword k of block a as {a[31:0], 5A5A_000k}.
    function automatic logic [BW-1:0] blk(input logic [AW-1:0] a);
        logic [BW-1:0] r;
        for (int k = 0; k < BW / 64; k++) r[64 * k +: 64] = {a[31:0], 32'h5A5A_0000 | 32'(k)};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] st, input logic [63:0] a, input logic [63:0] wd);
        bus.req_i = 1'b1; bus.we_i = we; bus.store_type_i = st; bus.addr_i = a; bus.write_data_i = wd;
    endtask

    task automatic idle_bus();
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.store_type_i = 2'b00; bus.addr_i = '0; bus.write_data_i = '0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_req_o === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic respond(input logic [BW-1:0] d);
        bus.mem_rdata_i = d; bus.mem_ready_i = 1'b1;
        tick();
        bus.mem_ready_i = 1'b0; bus.mem_rdata_i = '0;
    endtask

    task automatic test_reset();
        idle_bus(); bus.mem_ready_i = 1'b0; bus.mem_rdata_i = '0; arst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", bus.stall_o); end
        checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req_o); end
        checks++; if (bus.mem_we_o !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we_o); end
        checks++; if (bus.store_ma_o !== 1'b0) begin failures++; $display("FAIL reset_store_ma: got %b want 0", bus.store_ma_o); end
        arst_i = 1'b0;
        tick();
    endtask

    task automatic test_cold_load();
        bit ok;
        logic [BW-1:0] b;
        b = blk(64'h1000);
        drive(1'b0, 2'b11, 64'h1000, 64'h0); #1;
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL cold_miss_stall: got %b want 1", bus.stall_o); end
        checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL cold_req_registered: got %b want 0", bus.mem_req_o); end
        wait_req(ok);
        checks++; if (!ok) begin failures++; $display("FAIL cold_req_timeout: got no request want mem_req_o=1"); end
        checks++; if (bus.mem_we_o !== 1'b0) begin failures++; $display("FAIL cold_mem_we: got %b want 0", bus.mem_we_o); end
        checks++; if (bus.mem_addr_o !== 64'h1000) begin failures++; $display("FAIL cold_mem_addr: got %h want 1000", bus.mem_addr_o); end
        tick();
        checks++; if (bus.mem_req_o !== 1'b1 || bus.stall_o !== 1'b1) begin failures++; $display("FAIL cold_hold: got req=%b stall=%b want 1 1", bus.mem_req_o, bus.stall_o); end
        respond(b);
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL cold_stall_drop: got %b want 0", bus.stall_o); end
        checks++; if (bus.read_data_o !== b[63:0]) begin failures++; $display("FAIL cold_read_dw0: got %h want %h", bus.read_data_o, b[63:0]); end
        checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL cold_req_drop: got %b want 0", bus.mem_req_o); end
        drive(1'b0, 2'b11, 64'h1038, 64'h0); #1;
        checks++; if (bus.read_data_o !== b[511:448]) begin failures++; $display("FAIL cold_read_dw7: got %h want %h", bus.read_data_o, b[511:448]); end
        idle_bus();
        tick();
    endtask

    task automatic test_store_lanes();
        line0 = blk(64'h1000);
        line0[8 * 5 +: 8]   = 8'hAB;
        line0[8 * 16 +: 32] = 32'hCAFE_F00D;
        line0[8 * 62 +: 16] = 16'h1234;
        drive(1'b1, 2'b00, 64'h1005, 64'h0000_0000_0000_00AB); #1;
        checks++; if (bus.stall_o !== 1'b0 || bus.store_ma_o !== 1'b0) begin failures++; $display("FAIL sb_hit_flags: got stall=%b ma=%b want 0 0", bus.stall_o, bus.store_ma_o); end
        tick();
        drive(1'b1, 2'b10, 64'h1010, 64'hFFFF_FFFF_CAFE_F00D);
        tick();
        drive(1'b1, 2'b01, 64'h103E, 64'hEEEE_EEEE_EEEE_1234);
        tick();
        drive(1'b0, 2'b11, 64'h1000, 64'h0); #1;
        checks++; if (bus.read_data_o !== line0[63:0]) begin failures++; $display("FAIL sb_read: got %h want %h", bus.read_data_o, line0[63:0]); end
        checks++; if (bus.read_data_o[47:40] !== 8'hAB) begin failures++; $display("FAIL sb_byte5: got %h want ab", bus.read_data_o[47:40]); end
        drive(1'b0, 2'b11, 64'h1010, 64'h0); #1;
        checks++; if (bus.read_data_o !== line0[191:128]) begin failures++; $display("FAIL sw_read: got %h want %h", bus.read_data_o, line0[191:128]); end
        drive(1'b0, 2'b11, 64'h1038, 64'h0); #1;
        checks++; if (bus.read_data_o !== line0[511:448]) begin failures++; $display("FAIL sh_read: got %h want %h", bus.read_data_o, line0[511:448]); end
        idle_bus();
        tick();
    endtask

    task automatic test_misaligned();
        drive(1'b1, 2'b10, 64'h1002, 64'h1122_3344); #1;
        checks++; if (bus.store_ma_o !== 1'b1) begin failures++; $display("FAIL ma_sw: got %b want 1", bus.store_ma_o); end
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL ma_stall: got %b want 0", bus.stall_o); end
        tick();
        checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL ma_mem_req: got %b want 0", bus.mem_req_o); end
        drive(1'b1, 2'b01, 64'h1001, 64'h5566); #1;
        checks++; if (bus.store_ma_o !== 1'b1) begin failures++; $display("FAIL ma_sh: got %b want 1", bus.store_ma_o); end
        drive(1'b1, 2'b11, 64'h1004, 64'h7777_7777_7777_7777); #1;
        checks++; if (bus.store_ma_o !== 1'b1) begin failures++; $display("FAIL ma_sd: got %b want 1", bus.store_ma_o); end
        tick();
        drive(1'b0, 2'b11, 64'h1003, 64'h0); #1;
        checks++; if (bus.store_ma_o !== 1'b0) begin failures++; $display("FAIL ma_load: got %b want 0", bus.store_ma_o); end
        drive(1'b0, 2'b11, 64'h1000, 64'h0); #1;
        checks++; if (bus.read_data_o !== line0[63:0]) begin failures++; $display("FAIL ma_no_write: got %h want %h", bus.read_data_o, line0[63:0]); end
        idle_bus();
        tick();
    endtask

    task automatic test_plru_evict();
        bit ok;
        logic [63:0] fills [3];
        logic [BW-1:0] b;
        fills[0] = 64'h1100; fills[1] = 64'h1200; fills[2] = 64'h1300;
        for (int i = 0; i < 3; i++) begin
            b = blk(fills[i]);
            drive(1'b0, 2'b11, fills[i], 64'h0);
            wait_req(ok);
            checks++; if (!ok || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== fills[i]) begin failures++; $display("FAIL fill%0d_req: got ok=%b we=%b addr=%h want 1 0 %h", i, ok, bus.mem_we_o, bus.mem_addr_o, fills[i]); end
            respond(b);
            checks++; if (bus.read_data_o !== b[63:0]) begin failures++; $display("FAIL fill%0d_read: got %h want %h", i, bus.read_data_o, b[63:0]); end
            tick();
        end
        drive(1'b0, 2'b11, 64'h1400, 64'h0);
        wait_req(ok);
        checks++; if (!ok || bus.mem_we_o !== 1'b1) begin failures++; $display("FAIL wb_we: got ok=%b we=%b want 1 1", ok, bus.mem_we_o); end
        checks++; if (bus.mem_addr_o !== 64'h1000) begin failures++; $display("FAIL wb_addr: got %h want 1000", bus.mem_addr_o); end
        checks++; if (bus.mem_wdata_o !== line0) begin failures++; $display("FAIL wb_data: got %h want %h", bus.mem_wdata_o, line0); end
        respond('0);
        checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 64'h1400) begin failures++; $display("FAIL wb_then_refill: got req=%b we=%b addr=%h want 1 0 1400", bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o); end
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL wb_refill_stall: got %b want 1", bus.stall_o); end
        b = blk(64'h1400);
        respond(b);
        checks++; if (bus.stall_o !== 1'b0 || bus.read_data_o !== b[63:0]) begin failures++; $display("FAIL evict_read: got stall=%b data=%h want 0 %h", bus.stall_o, bus.read_data_o, b[63:0]); end
        tick();
        b = blk(64'h1100);
        drive(1'b0, 2'b11, 64'h1100, 64'h0); #1;
        checks++; if (bus.stall_o !== 1'b0 || bus.read_data_o !== b[63:0]) begin failures++; $display("FAIL keep_1100: got stall=%b data=%h want 0 %h", bus.stall_o, bus.read_data_o, b[63:0]); end
        tick();
        b = blk(64'h1000);
        drive(1'b0, 2'b11, 64'h1000, 64'h0);
        wait_req(ok);
        checks++; if (!ok || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 64'h1000) begin failures++; $display("FAIL clean_victim_req: got ok=%b we=%b addr=%h want 1 0 1000", ok, bus.mem_we_o, bus.mem_addr_o); end
        respond(b);
        checks++; if (bus.read_data_o !== b[63:0]) begin failures++; $display("FAIL refetch_read: got %h want %h", bus.read_data_o, b[63:0]); end
        tick();
        drive(1'b0, 2'b11, 64'h1200, 64'h0); #1;
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL victim_1200_gone: got stall=%b want 1", bus.stall_o); end
        idle_bus();
        drive(1'b0, 2'b11, 64'h1300, 64'h0); #1;
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL keep_1300: got stall=%b want 0", bus.stall_o); end
        idle_bus();
        tick();
    endtask

    task automatic test_reset_mid_refill();
        bit ok;
        logic [BW-1:0] b;
        b = blk(64'h2040);
        drive(1'b0, 2'b11, 64'h2040, 64'h0);
        wait_req(ok);
        checks++; if (!ok || bus.mem_addr_o !== 64'h2040) begin failures++; $display("FAIL rst_pre_req: got ok=%b addr=%h want 1 2040", ok, bus.mem_addr_o); end
        idle_bus();
        arst_i = 1'b1; #1;
        checks++; if (bus.mem_req_o !== 1'b0 || bus.mem_we_o !== 1'b0 || bus.stall_o !== 1'b0) begin failures++; $display("FAIL rst_abort: got req=%b we=%b stall=%b want 0 0 0", bus.mem_req_o, bus.mem_we_o, bus.stall_o); end
        tick();
        arst_i = 1'b0;
        bus.mem_rdata_i = b; bus.mem_ready_i = 1'b1;
        tick();
        bus.mem_ready_i = 1'b0; bus.mem_rdata_i = '0;
        tick();
        checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_late_ready: got req=%b want 0", bus.mem_req_o); end
        drive(1'b0, 2'b11, 64'h1400, 64'h0); #1;
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL rst_invalidated: got stall=%b want 1", bus.stall_o); end
        drive(1'b0, 2'b11, 64'h2040, 64'h0); #1;
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL rst_ready_ignored: got stall=%b want 1", bus.stall_o); end
        wait_req(ok);
        checks++; if (!ok || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 64'h2040) begin failures++; $display("FAIL rst_refetch_req: got ok=%b we=%b addr=%h want 1 0 2040", ok, bus.mem_we_o, bus.mem_addr_o); end
        respond(b);
        checks++; if (bus.read_data_o !== 64'h0000_2040_5A5A_0000) begin failures++; $display("FAIL rst_refetch_read: got %h want 000020405a5a0000", bus.read_data_o); end
        idle_bus();
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'b11, 64'h2048, 64'h0123_4567_89AB_CDEF); #1;
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL b2b_sd1_stall: got %b want 0", bus.stall_o); end
        tick();
        drive(1'b1, 2'b11, 64'h2050, 64'hFEDC_BA98_7654_3210); #1;
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL b2b_sd2_stall: got %b want 0", bus.stall_o); end
        tick();
        drive(1'b1, 2'b01, 64'h2052, 64'h0000_0000_0000_BEEF);
        tick();
        drive(1'b0, 2'b11, 64'h2048, 64'h0); #1;
        checks++; if (bus.read_data_o !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL b2b_read1: got %h want 0123456789abcdef", bus.read_data_o); end
        drive(1'b0, 2'b11, 64'h2050, 64'h0); #1;
        checks++; if (bus.read_data_o !== 64'hFEDC_BA98_BEEF_3210) begin failures++; $display("FAIL b2b_read2: got %h want fedcba98beef3210", bus.read_data_o); end
        drive(1'b0, 2'b11, 64'h2044, 64'h0); #1;
        checks++; if (bus.read_data_o !== 64'h0000_2040_5A5A_0000) begin failures++; $display("FAIL b2b_read0: got %h want 000020405a5a0000", bus.read_data_o); end
        idle_bus();
        tick();
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_store_lanes();
        test_misaligned();
        test_plru_evict();
        test_reset_mid_refill();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
